// File: rtl/const_table_pkg.sv
// Constant lookup table contents, entry type and arbiter FSM states shared by the
// arbiter and its consumers.
package const_table_pkg;

  localparam int DATA_W      = 10;
  localparam int TABLE_DEPTH = 4;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t TABLE [TABLE_DEPTH] = '{10'd0, 10'd1, 10'd512, 10'd1023};

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

endpackage

// File: rtl/const_table_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching from rr_ptr
// upward, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   winner
);

  // Walk the offsets from farthest to nearest so the nearest set request wins.
  always_comb begin : search
    int idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/const_table_arbiter.sv
// Round-robin shared access to the constant table: one access in flight,
// grant one cycle after the request is sampled, response one cycle after the grant.
module const_table_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 10,
  parameter int ADDR_W      = 2,
  parameter int TABLE_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_err,
  output logic                      o_busy
);
  import const_table_pkg::*;

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int TIDX_W = $clog2(TABLE_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(TABLE_DEPTH);

  state_e             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               pick_vld;
  logic [PTR_W-1:0]   winner;
  logic               in_range;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (i_req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .winner (winner)
  );

  assign in_range = ({1'b0, addr_q} < DEPTH_C);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      o_gnt    <= '0;
      o_rvalid <= '0;
      o_rdata  <= '0;
      o_err    <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state  <= READ;
            id_q   <= winner;
            addr_q <= i_addr[winner*ADDR_W +: ADDR_W];
            o_gnt  <= NUM_REQ'(1) << winner;
            o_busy <= 1'b1;
          end
        end
        READ: begin
          state    <= RESP;
          o_gnt    <= '0;
          o_rvalid <= NUM_REQ'(1) << id_q;
          o_err    <= !in_range;
          o_rdata  <= in_range ? TABLE[addr_q[TIDX_W-1:0]] : '0;
        end
        RESP: begin
          state    <= IDLE;
          o_rvalid <= '0;
          o_err    <= 1'b0;
          o_busy   <= 1'b0;
          rr_ptr   <= (id_q == PTR_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_const_table_arbiter.sv
// Directed bench for const_table_arbiter (3 requesters, 3-bit addresses so the
// out-of-range path is reachable).
module tb_const_table_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic                      busy;

  int passed = 0;
  int total  = 0;

  const_table_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TABLE_DEPTH(4)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_addr   (addr),
    .o_gnt    (gnt),
    .o_rvalid (rvalid),
    .o_rdata  (rdata),
    .o_err    (err),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(gnt),    32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_rdata"},  32'(rdata),  32'd0);
    chk({tag, "_err"},    32'(err),    32'd0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
  endtask

  logic [2:0] exp_gnt [4];
  int         exp_dat [4];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;

    // Reset held: requests must not produce anything.
    #1;
    chk_all_zero("rst0");
    req = 3'b111;
    tick();
    chk_all_zero("rst1");
    req = 3'b010;
    tick();
    chk_all_zero("rst2");
    req = 3'b000;
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt",  32'(gnt),  32'd0);

    // Single access: requester 1, addr 2 -> 512.
    req  = 3'b010;
    addr = {3'd0, 3'd2, 3'd0};
    tick();
    chk("single_gnt",  32'(gnt),    32'b010);
    chk("single_busy", 32'(busy),   32'd1);
    chk("single_rv0",  32'(rvalid), 32'd0);
    req = 3'b000;
    tick();
    chk("single_rvalid", 32'(rvalid), 32'b010);
    chk("single_rdata",  32'(rdata),  32'd512);
    chk("single_err",    32'(err),    32'd0);
    chk("single_gnt0",   32'(gnt),    32'd0);
    tick();
    chk("single_rv_end", 32'(rvalid), 32'd0);
    chk("single_idle",   32'(busy),   32'd0);

    // Short reset so round-robin starts from requester 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Fairness: all three held, addrs {3,1,0}.
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_dat = '{0, 1, 1023, 0};
    req  = 3'b111;
    addr = {3'd3, 3'd1, 3'd0};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_gnt[k]));
      tick();
      chk($sformatf("rr%0d_rvalid", k), 32'(rvalid), 32'(exp_gnt[k]));
      chk($sformatf("rr%0d_rdata", k),  32'(rdata),  32'(exp_dat[k]));
      if (k == 3) req = 3'b000;
      tick();
      chk($sformatf("rr%0d_gap_gnt", k),  32'(gnt),    32'd0);
      chk($sformatf("rr%0d_gap_busy", k), 32'(busy),   32'd0);
    end

    // Wrap: serve req2 (ptr at 1), then 101 must go to req0 then req2.
    req  = 3'b100;
    addr = {3'd2, 3'd0, 3'd1};
    tick();
    chk("wrap_gnt2", 32'(gnt), 32'b100);
    req = 3'b101;
    tick();
    chk("wrap_rv2",   32'(rvalid), 32'b100);
    chk("wrap_dat2",  32'(rdata),  32'd512);
    tick();
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'b001);
    tick();
    chk("wrap_rv0",  32'(rvalid), 32'b001);
    chk("wrap_dat0", 32'(rdata),  32'd1);
    tick();
    tick();
    chk("wrap_gnt2b", 32'(gnt), 32'b100);
    req = 3'b000;
    tick();
    chk("wrap_rv2b",  32'(rvalid), 32'b100);
    chk("wrap_dat2b", 32'(rdata),  32'd512);
    tick();
    chk("rdata_hold", 32'(rdata),  32'd512);
    chk("hold_rv",    32'(rvalid), 32'd0);

    // Out of range: addr0=5.
    req  = 3'b001;
    addr = {3'd0, 3'd0, 3'd5};
    tick();
    chk("oor_gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();
    chk("oor_rvalid", 32'(rvalid), 32'b001);
    chk("oor_err",    32'(err),    32'd1);
    chk("oor_rdata",  32'(rdata),  32'd0);
    tick();
    chk("oor_err_clr", 32'(err), 32'd0);

    // Boundary: addr1 == depth is out of range.
    req  = 3'b010;
    addr = {3'd0, 3'd4, 3'd0};
    tick();
    chk("bnd_gnt", 32'(gnt), 32'b010);
    req = 3'b000;
    tick();
    chk("bnd_rvalid", 32'(rvalid), 32'b010);
    chk("bnd_err",    32'(err),    32'd1);
    tick();

    // Reset during READ: access dropped, pointer back to 0 (was 2).
    req  = 3'b001;
    addr = {3'd0, 3'd3, 3'd3};
    tick();
    chk("mid_gnt", 32'(gnt), 32'b001);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    chk("mid_no_rv", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    req   = 3'b110;
    tick();
    chk("mid_gnt1", 32'(gnt), 32'b010);
    req = 3'b000;
    tick();
    chk("mid_rv1",  32'(rvalid), 32'b010);
    chk("mid_dat1", 32'(rdata),  32'd1023);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
